inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction fetch stage upstream of decode/FSM control. Owns the fetch PC,
//  issues sequential reads to the synchronous instruction memory, and buffers
//  returned words with their PCs in a small prefetch queue. Decode consumes
//  the queue through a valid/ready handshake. Branch/jump redirects flush the
//  queue and restart fetch at a new address.
// PARAMETERS
//  ADDR_W    32     width of PC / imem address
//  DATA_W    32     instruction width
//  DEPTH     4      queue entries (power of 2, >=2)
//  RESET_PC  32'h0  fetch PC after reset
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       asynchronous reset, active-high
//  redirect_valid  in   1       flush queue, restart fetch at redirect_pc
//  redirect_pc     in   ADDR_W  new fetch address; bits [1:0] ignored (forced 0)
//  imem_req        out  1       read request this cycle (combinational)
//  imem_addr       out  ADDR_W  read address, = fetch_pc
//  imem_rdata      in   DATA_W  read data, valid exactly 1 cycle after imem_req
//  inst_valid      out  1       queue head holds an instruction
//  inst_ready      in   1       decode accepts the head this cycle
//  inst_data       out  DATA_W  head instruction (show-ahead)
//  inst_pc         out  ADDR_W  PC of the head instruction
// BEHAVIOUR
//  - Reset (async): fetch_pc=RESET_PC, queue empty, in-flight flag clear,
//    inst_valid=0, inst_data=0, inst_pc=0. imem_req=0 while rst is high.
//  - Issue: imem_req = !rst && !redirect_valid && (count + inflight < DEPTH).
//    Same-cycle pop gives no issue credit. On issue: fetch_pc <= fetch_pc+4,
//    inflight <= 1, tag <= fetch_pc. Otherwise inflight <= 0.
//  - Return: in the cycle after an issue, imem_rdata+tag are written to the
//    tail unless squashed. Push and pop may occur in the same cycle; count
//    is unchanged.
//  - Pop: on inst_valid && inst_ready, head advances. inst_data and inst_pc
//    come from the head entry (registers, not imem). When the queue is
//    empty, both hold their last value.
//  - Latency: req in cycle N, rdata in N+1, inst_valid in N+2. First req
//    occurs in the first cycle after rst falls. With inst_ready held high,
//    throughput is 1 instruction/cycle, sustained.
//  - Redirect (priority over push, pop and issue): queue cleared,
//    fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}, and an in-flight response
//    returning next cycle is discarded (squash flag). A pop in the same
//    cycle is not counted as accepted. inst_valid=0 in the following cycle.
//    The first new req is issued in the following cycle.
//  - Back-to-back redirects: the last one wins. Each clears the queue.
//  - Full: no req while count+inflight==DEPTH. No overflow is possible.
//  - Wrap: fetch_pc ADDR_W'hFFFF_FFFC + 4 -> 0, with no flag.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is
//    log2(DEPTH)+1 bits.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds out ports perf_fetch_cnt[31:0] (+1 per
//    accepted inst handshake, wraps) and perf_flush_cnt[15:0] (+1 per
//    redirect cycle, saturates at 16'hFFFF). Both are reset to 0 by rst.
//  FETCH_PERF_EN undefined: the ports and counters are absent.
//    Fetch behaviour is identical in both builds.
// TESTING
//  1 Reset release, inst_ready=1, imem returns addr as data -> inst_pc
//    0,4,8,... one per cycle from 2 cycles after first req; inst_data==inst_pc.
//  2 inst_ready=0 for 10 cycles -> exactly DEPTH=4 reqs (0..C), imem_req
//    held 0, inst_valid=1 with inst_pc=0. Raise ready -> 0,4,8,C,10 in order
//    with no gap beyond startup.
//  3 Redirect to 32'h100 while 3 entries are queued and 1 is in flight ->
//    next cycle inst_valid=0 and imem_addr=32'h100. The stale response is
//    dropped. The next inst_pc seen is 32'h100.
//  4 Redirect_pc=32'h203 in the same cycle as a pop -> fetch restarts at
//    32'h200. The popped entry is not counted (perf_fetch_cnt unchanged
//    if FETCH_PERF_EN).
//  5 Redirect to 32'hFFFF_FFF8, ready=1 -> inst_pc sequence FFFF_FFF8,
//    FFFF_FFFC, 0, 4.
//  6 Assert rst mid-stream with a full queue -> outputs immediately return
//    to reset values. After release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Instruction fetch stage. Owns the fetch PC and issues
//               sequential reads to a synchronous instruction memory. It
//               buffers returned words and their PCs in a small prefetch
//               queue, which decode drains through a valid/ready handshake.
//               A redirect flushes the queue and restarts fetch at a new
//               word-aligned address.
// Optional    : define FETCH_PERF_EN to add the performance counters
//               perf_fetch_cnt (accepted handshakes, wraps) and
//               perf_flush_cnt (redirect cycles, saturates).
// Ports       : clk, rst (async, active-high)
//               redirect_valid / redirect_pc   - flush and restart request
//               imem_req / imem_addr           - memory read request (comb)
//               imem_rdata                     - read data, one cycle later
//               inst_valid / inst_ready        - decode handshake
//               inst_data / inst_pc            - show-ahead queue head
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]   c_DEPTH_OCC = (c_CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  c_PC_STEP   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0]  c_ALIGN     = ~(ADDR_W'(3));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_inflight;
    logic               r_squash;
    logic [ADDR_W-1:0]  r_tag;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc   [DEPTH];
    logic [DATA_W-1:0]  r_last_data;
    logic [ADDR_W-1:0]  r_last_pc;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [c_CNT_W:0]  w_occupancy;
    logic [ADDR_W-1:0] w_redirect_aligned;

    assign w_empty            = (r_count == '0);
    assign w_redirect_aligned = redirect_pc & c_ALIGN;

    // A redirect cancels both the handshake and any returning response.
    assign w_pop  = !w_empty && inst_ready && !redirect_valid;
    assign w_push = r_inflight && !r_squash && !redirect_valid;

    // Slots already taken plus the one reserved by an outstanding read.
    // A pop in the same cycle deliberately frees no slot for issue, which
    // keeps the request path independent of inst_ready.
    assign w_occupancy = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_issue     = !rst && !redirect_valid && (w_occupancy < c_DEPTH_OCC);

    assign imem_req   = w_issue;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = !w_empty;

    // Show-ahead head; when empty, keep presenting the last head seen.
    assign inst_data  = w_empty ? r_last_data : r_mem_data[r_rd_ptr];
    assign inst_pc    = w_empty ? r_last_pc   : r_mem_pc[r_rd_ptr];

    // ------------------------------------------------------------------
    // Fetch PC, outstanding-read tracking and queue pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_squash   <= 1'b0;
            r_tag      <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_squash <= redirect_valid;
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_aligned;
                r_inflight <= 1'b0;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                    r_tag      <= r_fetch_pc;
                    r_inflight <= 1'b1;
                end else begin
                    r_inflight <= 1'b0;
                end

                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end

                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_CNT_ONE;
                end
            end
        end
    end

    // Queue storage: written only, never reset; entries are only visible
    // through the head while the count says they are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_tag;
        end
    end

    // Remember the currently presented head so the outputs hold steady
    // once the queue drains or is flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_data <= '0;
            r_last_pc   <= '0;
        end else if (!w_empty) begin
            r_last_data <= r_mem_data[r_rd_ptr];
            r_last_pc   <= r_mem_pc[r_rd_ptr];
        end
    end

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_fetch;
    logic [15:0] r_perf_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (redirect_valid && (r_perf_flush != 16'hFFFF)) begin
                r_perf_flush <= r_perf_flush + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
`else
    // Counters are not built; fetch behaviour is unaffected.
`endif

endmodule
`default_nettype wire
